// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared types for the RAM-backed FIFO controller.
// The controller imports this package to classify each cycle's accepted operations.
package ram_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e op_of(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/simple_dual_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The two ports may be clocked independently.
module simple_dual_ram #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 16
) (
  input  logic                     wclk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [SIZE-1:0]          wdata,
  input  logic                     rclk,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [SIZE-1:0]          rdata
);

  logic [SIZE-1:0] mem [DEPTH];

  // NOTE: the array and the read register have no reset, so they map onto plain block RAM.
  always_ff @(posedge wclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge rclk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller on top of a simple dual-port RAM.
// It holds pointers, occupancy, flags and error pulses; the RAM holds all data.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       wput,
  output logic                       full,
  input  logic                       rget,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_ok;
  logic          rd_ok;
  logic [CW-1:0] count_next;

  // Gating on the current full/empty flags alone keeps the RAM from seeing
  // a read and a write to the same address in one cycle.
  assign wr_ok = rst && wput && !full;
  assign rd_ok = rst && rget && !empty;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    unique case (op_of(wr_ok, rd_ok))
      OP_PUSH: count_next = count + CW'(1);
      OP_POP:  count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      count      <= count_next;
      full       <= (count_next == CW'(DEPTH));
      empty      <= (count_next == '0);
      dout_valid <= rd_ok;
      overflow   <= wput && full;
      underflow  <= rget && empty;
    end
  end

  simple_dual_ram #(
    .SIZE  (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .wclk  (clk),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (din),
    .rclk  (clk),
    .re    (rd_ok),
    .raddr (rptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed vector bench for ram_fifo_ctrl (DEPTH=4, WIDTH=8), followed by a
// random push/pop sequence compared against a queue model.
module tb_ram_fifo_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             wput;
  logic             rget;
  logic             full;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wput       (wput),
    .full       (full),
    .rget       (rget),
    .dout       (dout),
    .dout_valid (dout_valid),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  typedef struct {
    logic       rst;
    logic       wput;
    logic       rget;
    logic [7:0] din;
    int         cnt;
    logic       full;
    logic       empty;
    logic       dv;
    logic [7:0] dout;
    logic       ov;
    logic       uf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic w, input logic g, input logic [7:0] d,
                     input int c, input logic f, input logic e, input logic dv,
                     input logic [7:0] dq, input logic ov, input logic uf);
    vec_t v;
    v.rst = r; v.wput = w; v.rget = g; v.din = d; v.cnt = c; v.full = f;
    v.empty = e; v.dv = dv; v.dout = dq; v.ov = ov; v.uf = uf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic g, input logic [7:0] d);
    @(negedge clk);
    rst = r; wput = w; rget = g; din = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] model[$];
  logic       exp_dv;
  logic [7:0] exp_dout;

  initial begin
    rst = 1'b0; wput = 1'b0; rget = 1'b0; din = '0;

    // rst wput rget din | count full empty dv dout ov uf
    add(0,0,0,8'h00, 0,0,1,0,8'h00,0,0);
    add(0,1,1,8'h99, 0,0,1,0,8'h00,0,0);  // requests ignored in reset
    add(1,0,0,8'h00, 0,0,1,0,8'h00,0,0);
    add(1,1,0,8'h11, 1,0,0,0,8'h00,0,0);
    add(1,1,0,8'h22, 2,0,0,0,8'h00,0,0);
    add(1,1,0,8'h33, 3,0,0,0,8'h00,0,0);
    add(1,1,0,8'h44, 4,1,0,0,8'h00,0,0);
    add(1,1,0,8'h55, 4,1,0,0,8'h00,1,0);  // overflow
    add(1,0,1,8'h00, 3,0,0,1,8'h11,0,0);
    add(1,0,1,8'h00, 2,0,0,1,8'h22,0,0);
    add(1,0,1,8'h00, 1,0,0,1,8'h33,0,0);
    add(1,0,1,8'h00, 0,0,1,1,8'h44,0,0);
    add(1,0,1,8'h00, 0,0,1,0,8'h00,0,1);  // underflow
    add(1,1,0,8'h01, 1,0,0,0,8'h00,0,0);
    add(1,1,0,8'h02, 2,0,0,0,8'h00,0,0);
    for (int i = 0; i < 10; i++)          // streaming across pointer wrap
      add(1,1,1,8'(i+3), 2,0,0,1,8'(i+1),0,0);
    add(1,1,0,8'h0D, 3,0,0,0,8'h00,0,0);
    add(1,1,0,8'h0E, 4,1,0,0,8'h00,0,0);
    add(1,1,1,8'hEE, 3,0,0,1,8'h0B,1,0);  // both at full: read only
    add(1,0,1,8'h00, 2,0,0,1,8'h0C,0,0);
    add(1,0,1,8'h00, 1,0,0,1,8'h0D,0,0);
    add(1,0,1,8'h00, 0,0,1,1,8'h0E,0,0);
    add(1,1,1,8'h77, 1,0,0,0,8'h00,0,1);  // both at empty: write only
    add(1,0,1,8'h00, 0,0,1,1,8'h77,0,0);
    add(1,1,0,8'h31, 1,0,0,0,8'h00,0,0);
    add(1,1,0,8'h32, 2,0,0,0,8'h00,0,0);
    add(1,1,0,8'h33, 3,0,0,0,8'h00,0,0);
    add(0,0,1,8'h00, 0,0,1,0,8'h00,0,0);  // reset during rget
    add(1,0,0,8'h00, 0,0,1,0,8'h00,0,0);
    add(1,1,0,8'hA5, 1,0,0,0,8'h00,0,0);
    add(1,0,1,8'h00, 0,0,1,1,8'hA5,0,0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wput, vecs[i].rget, vecs[i].din);
      check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].full));
      check($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].empty));
      check($sformatf("v%0d dout_valid", i), 32'(dout_valid), 32'(vecs[i].dv));
      check($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].ov));
      check($sformatf("v%0d underflow", i), 32'(underflow), 32'(vecs[i].uf));
      if (vecs[i].dv)
        check($sformatf("v%0d dout", i), 32'(dout), 32'(vecs[i].dout));
    end

    // Random traffic against a queue model; state is empty after the table.
    model.delete();
    for (int n = 0; n < 300; n++) begin
      logic w, g, wa, ga, ov_e, uf_e;
      logic [7:0] d;
      w = 1'($urandom_range(0, 1));
      g = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      wa = w && (model.size() < DEPTH);
      ga = g && (model.size() > 0);
      ov_e = w && (model.size() == DEPTH);
      uf_e = g && (model.size() == 0);
      exp_dv = ga;
      exp_dout = ga ? model.pop_front() : 8'h00;
      if (wa) model.push_back(d);
      step(1'b1, w, g, d);
      check($sformatf("r%0d count", n), 32'(count), 32'(model.size()));
      check($sformatf("r%0d full", n), 32'(full), 32'(model.size() == DEPTH));
      check($sformatf("r%0d empty", n), 32'(empty), 32'(model.size() == 0));
      check($sformatf("r%0d dout_valid", n), 32'(dout_valid), 32'(exp_dv));
      check($sformatf("r%0d overflow", n), 32'(overflow), 32'(ov_e));
      check($sformatf("r%0d underflow", n), 32'(underflow), 32'(uf_e));
      if (exp_dv)
        check($sformatf("r%0d dout", n), 32'(dout), 32'(exp_dout));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low (0 = reset).
REQ-005 din  input  WIDTH  write data.
REQ-006 wput  input  1  write request.
REQ-007 full  output  1  FIFO holds DEPTH entries.
REQ-008 rget  input  1  read request.
REQ-009 dout  output  WIDTH  read data; don't-care while dout_valid=0.
REQ-010 dout_valid  output  1  dout carries the word popped in the previous cycle.
REQ-011 empty  output  1  FIFO holds 0 entries.
REQ-012 count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-013 overflow  output  1  one-cycle pulse: wput while full.
REQ-014 underflow  output  1  one-cycle pulse: rget while empty.

Function
REQ-015 Write accepted iff wput=1 and full=0; din is stored at wptr, and wptr increments.
REQ-016 Read accepted iff rget=1 and empty=0; the RAM read of rptr is issued, and rptr increments.
REQ-017 Read latency is exactly 1 cycle: dout and dout_valid=1 appear in the cycle after acceptance.
REQ-018 dout_valid is 0 in any cycle not following an accepted read.
REQ-019 Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-020 count +1 on an accepted write only, -1 on an accepted read only, and unchanged when both or neither are accepted.
REQ-021 full = (count==DEPTH) and empty = (count==0), both registered and consistent with count in the same cycle.
REQ-022 When full, wput is ignored even if a read is accepted in the same cycle, so the RAM never sees the same address read and written in one cycle.
REQ-023 When empty, rget is ignored even if a write is accepted in the same cycle; a written word is readable no earlier than the next cycle.
REQ-024 When not full and not empty, a simultaneous write and read are both accepted.
REQ-025 overflow and underflow are registered, high for exactly the cycle after the offending request, and have no effect on state.
REQ-026 Data order is strictly first-in first-out; no word is lost or duplicated across pointer wrap.

Reset
REQ-027 While rst=0 at a clock edge: wptr=0, rptr=0, count=0, empty=1, full=0, dout_valid=0, overflow=0, underflow=0.
REQ-028 Reset asserted mid-operation discards all stored entries, and any read issued in the reset cycle produces no dout_valid.
REQ-029 RAM contents and dout are not reset.
REQ-030 wput and rget are ignored in any cycle where rst=0.

Structure
REQ-031 No shared package is required; address width is derived locally as $clog2(DEPTH).
REQ-032 Storage is a single instance of the team's simple dual-port RAM sub-module (simple_dual_ram, SIZE=WIDTH, DEPTH=DEPTH), with both its clocks tied to clk.
REQ-033 The controller holds only pointers, count, flags and pulse registers; it contains no storage array of its own.
REQ-034 Target size is 120-250 lines of RTL.

Verification (DEPTH=4, WIDTH=8)
REQ-035 Reset, then idle -> empty=1, full=0, count=0, dout_valid=0, no overflow/underflow pulses.
REQ-036 Write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4 and full=1 after the fourth; a fifth wput of 0x55 -> overflow pulse, count stays 4.
REQ-037 From full, rget for four cycles -> dout 0x11,0x22,0x33,0x44 each one cycle after its rget with dout_valid=1, then empty=1; a further rget -> underflow pulse and dout_valid=0.
REQ-038 Continuous write and read at count=2 for 10 cycles across pointer wrap -> count stays 2 and the output sequence equals the input sequence delayed by 2 entries.
REQ-039 Simultaneous wput and rget at full -> read accepted, write ignored, overflow pulse, count 3; simultaneous at empty -> write accepted, read ignored, underflow pulse, count 1.
REQ-040 Write 3 words, then assert rst for 1 cycle during an rget -> next cycle empty=1, count=0, dout_valid=0; a subsequent write/read of 0xA5 returns 0xA5.
